branch_resolve: RTL and testbench

- Execute-stage branch resolution, directly downstream of the comparator unit.
- Consumes the registered 1-bit comparator result with the decoded control-transfer info. Computes taken/target, static predict-not-taken.
- Issues a one-cycle registered redirect to fetch and drops the wrong-path shadow arriving behind a taken transfer.
- Produces link value, misaligned-target flag and branch statistics counters.

---
 rtl/branch_resolve_if.sv | 36 +++
 rtl/branch_resolve.sv | 84 ++++++++
 tb/tb_branch_resolve.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - execute-stage branch resolution handshake and result bundle
interface branch_resolve_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stall_in;
  logic                 invalidate_in;
  logic                 valid_in;
  logic [31:0]          pc_in;
  logic [31:0]          imm_in;
  logic [31:0]          rs1_in;
  logic                 is_branch;
  logic                 is_jal;
  logic                 is_jalr;
  logic                 cmp_result;
  logic                 valid_out;
  logic [31:0]          link_out;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 misaligned_out;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] taken_count;

  modport master (
    output stall_in, invalidate_in, valid_in, pc_in, imm_in, rs1_in,
           is_branch, is_jal, is_jalr, cmp_result,
    input  valid_out, link_out, redirect_valid, redirect_pc, misaligned_out,
           branch_count, taken_count
  );

  modport slave (
    input  stall_in, invalidate_in, valid_in, pc_in, imm_in, rs1_in,
           is_branch, is_jal, is_jalr, cmp_result,
    output valid_out, link_out, redirect_valid, redirect_pc, misaligned_out,
           branch_count, taken_count
  );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - taken/target resolution, one-cycle fetch redirect, wrong-path shadow drop
module branch_resolve #(
  parameter int SHADOW    = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  branch_resolve_if.slave br_if
);
  localparam logic [1:0]           SHADOW_LOAD = 2'(SHADOW);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_valid;
  logic [31:0]          r_link;
  logic                 r_redirect;
  logic [31:0]          r_redirect_pc;
  logic                 r_misaligned;
  logic [1:0]           r_shadow;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_taken_cnt;

  logic        w_accept;
  logic        w_taken;
  logic        w_br_taken;
  logic [31:0] w_sum;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_redirect;

  assign w_accept   = br_if.valid_in & ~br_if.stall_in & ~br_if.invalidate_in & (r_shadow == 2'd0);
  assign w_br_taken = br_if.is_branch & br_if.cmp_result;
  assign w_taken    = br_if.is_jal | br_if.is_jalr | w_br_taken;
  assign w_sum      = (br_if.is_jalr ? br_if.rs1_in : br_if.pc_in) + br_if.imm_in;
  // jalr clears bit0 before the alignment check, so only bit1 can flag misalignment
  assign w_target     = {w_sum[31:1], w_sum[0] & ~br_if.is_jalr};
  assign w_misaligned = w_taken & w_target[1];
  assign w_redirect   = w_taken & ~w_misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_link        <= 32'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_misaligned  <= 1'b0;
      r_shadow      <= 2'd0;
      r_branch_cnt  <= '0;
      r_taken_cnt   <= '0;
    end else begin
      r_redirect <= 1'b0;
      if (br_if.invalidate_in) begin
        r_valid      <= 1'b0;
        r_misaligned <= 1'b0;
        r_shadow     <= 2'd0;
      end else if (w_accept) begin
        r_valid      <= 1'b1;
        r_link       <= br_if.pc_in + 32'd4;
        r_misaligned <= w_misaligned;
        if (w_redirect) begin
          r_redirect    <= 1'b1;
          r_redirect_pc <= w_target;
          r_shadow      <= SHADOW_LOAD;
        end
        if (br_if.is_branch) r_branch_cnt <= r_branch_cnt + CNT_ONE;
        if (w_br_taken)      r_taken_cnt  <= r_taken_cnt + CNT_ONE;
      end else begin
        if (!br_if.stall_in) begin
          r_valid      <= 1'b0;
          r_misaligned <= 1'b0;
        end
        // shadow runs down even while stalled
        if (r_shadow != 2'd0) r_shadow <= r_shadow - 2'd1;
      end
    end
  end

  assign br_if.valid_out      = r_valid;
  assign br_if.link_out       = r_link;
  assign br_if.redirect_valid = r_redirect;
  assign br_if.redirect_pc    = r_redirect_pc;
  assign br_if.misaligned_out = r_misaligned;
  assign br_if.branch_count   = r_branch_cnt;
  assign br_if.taken_count    = r_taken_cnt;
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve with directed vectors
module tb_branch_resolve;
  logic clk;
  logic reset;

  branch_resolve_if #(.CNT_WIDTH(4)) br_if ();

  branch_resolve #(.SHADOW(1), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .br_if (br_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] link;
    logic        mis;
    logic        redir;
    logic [31:0] rpc;
    logic [3:0]  bc;
    logic [3:0]  tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] m_bc = 4'd0;
  logic [3:0] m_tc = 4'd0;
  logic prev_stall = 1'b0;
  logic prev_inval = 1'b0;
  logic prev_redir = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    prev_stall <= br_if.stall_in;
    prev_inval <= br_if.invalidate_in;
  end

  // monitor: a fresh result appears after any edge that was neither stalled nor flushed
  always @(negedge clk) begin
    if (!reset) begin
      if (br_if.redirect_valid) chk("redirect_pulse_width", 32'(prev_redir), 32'd0);
      prev_redir <= br_if.redirect_valid;
      if (br_if.valid_out && !prev_stall && !prev_inval) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_out", 32'(br_if.valid_out), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("link_out",       br_if.link_out,             e.link);
          chk("misaligned_out", 32'(br_if.misaligned_out),  32'(e.mis));
          chk("redirect_valid", 32'(br_if.redirect_valid),  32'(e.redir));
          if (e.redir) chk("redirect_pc", br_if.redirect_pc, e.rpc);
          chk("branch_count",   32'(br_if.branch_count),    32'(e.bc));
          chk("taken_count",    32'(br_if.taken_count),     32'(e.tc));
        end
      end
    end else begin
      prev_redir <= 1'b0;
    end
  end

  task automatic drive_idle();
    br_if.valid_in = 1'b0; br_if.stall_in = 1'b0; br_if.invalidate_in = 1'b0;
    br_if.is_branch = 1'b0; br_if.is_jal = 1'b0; br_if.is_jalr = 1'b0; br_if.cmp_result = 1'b0;
    br_if.pc_in = 32'd0; br_if.imm_in = 32'd0; br_if.rs1_in = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  // one cycle of stimulus; expected values are hand-computed by the caller
  task automatic step(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                      input logic br, input logic jal, input logic jalr, input logic cmp,
                      input logic acc, input logic [31:0] e_link, input logic e_redir,
                      input logic [31:0] e_rpc, input logic e_mis);
    exp_t e;
    @(posedge clk); #1;
    drive_idle();
    br_if.valid_in = 1'b1; br_if.pc_in = pc; br_if.imm_in = imm; br_if.rs1_in = rs1;
    br_if.is_branch = br; br_if.is_jal = jal; br_if.is_jalr = jalr; br_if.cmp_result = cmp;
    if (acc) begin
      if (br) m_bc = m_bc + 4'd1;
      if (br && cmp) m_tc = m_tc + 4'd1;
      e.link = e_link; e.mis = e_mis; e.redir = e_redir; e.rpc = e_rpc; e.bc = m_bc; e.tc = m_tc;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_valid_out",   32'(br_if.valid_out), 32'd0);
    chk("reset_redirect",    32'(br_if.redirect_valid), 32'd0);
    chk("reset_link",        br_if.link_out, 32'd0);
    chk("reset_branch_cnt",  32'(br_if.branch_count), 32'd0);

    // not-taken beq, then taken bne with a dropped shadow slot
    step(32'h100, 32'h20, 0, 1, 0, 0, 0, 1, 32'h104, 0, 0, 0);
    step(32'h100, 32'hFFFF_FFF0, 0, 1, 0, 0, 1, 1, 32'h104, 1, 32'hF0, 0);
    step(32'hF0, 32'h4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(32'hF4, 32'h8, 0, 1, 0, 0, 0, 1, 32'hF8, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("shadow_drop_bc", 32'(br_if.branch_count), 32'd3);

    // jalr aligned, jalr misaligned (no shadow), then jal
    step(32'h40, 32'h3, 32'h2001, 0, 0, 1, 0, 1, 32'h44, 1, 32'h2004, 0);
    idle(1);
    step(32'h40, 32'h1, 32'h2001, 0, 0, 1, 0, 1, 32'h44, 0, 0, 1);
    step(32'h200, 32'h10, 0, 0, 1, 0, 0, 1, 32'h204, 1, 32'h210, 0);
    idle(1);

    // taken branch then 3 stalled cycles with a held instruction waiting
    step(32'h300, 32'h40, 0, 1, 0, 0, 1, 1, 32'h304, 1, 32'h340, 0);
    @(posedge clk); #1;
    br_if.stall_in = 1'b1; br_if.valid_in = 1'b1; br_if.is_branch = 1'b1;
    br_if.pc_in = 32'h500; br_if.imm_in = 32'h0; br_if.cmp_result = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("stall_valid_held", 32'(br_if.valid_out), 32'd1);
        chk("stall_link_held",  br_if.link_out, 32'h304);
        chk("stall_no_redirect", 32'(br_if.redirect_valid), 32'd0);
      end
      if (i < 2) @(posedge clk);
    end
    @(negedge clk);
    chk("stall_valid_held", 32'(br_if.valid_out), 32'd1);
    chk("stall_no_redirect", 32'(br_if.redirect_valid), 32'd0);
    step(32'h500, 32'h0, 0, 1, 0, 0, 0, 1, 32'h504, 0, 0, 0);
    idle(1);

    // invalidate kills a simultaneous taken jal
    @(posedge clk); #1;
    br_if.valid_in = 1'b1; br_if.is_jal = 1'b1; br_if.invalidate_in = 1'b1;
    br_if.pc_in = 32'h600; br_if.imm_in = 32'h100;
    @(negedge clk);
    chk("inval_valid_out", 32'(br_if.valid_out), 32'd0);
    chk("inval_redirect",  32'(br_if.redirect_valid), 32'd0);
    chk("inval_branch_cnt", 32'(br_if.branch_count), 32'd5);
    chk("inval_taken_cnt",  32'(br_if.taken_count), 32'd2);
    idle(1);

    // async reset while redirect is in flight and shadow is pending
    step(32'h700, 32'h10, 0, 1, 0, 0, 1, 1, 32'h704, 1, 32'h710, 0);
    idle(1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid",    32'(br_if.valid_out), 32'd0);
    chk("async_rst_redirect", 32'(br_if.redirect_valid), 32'd0);
    chk("async_rst_rpc",      br_if.redirect_pc, 32'd0);
    chk("async_rst_link",     br_if.link_out, 32'd0);
    chk("async_rst_bc",       32'(br_if.branch_count), 32'd0);
    m_bc = 4'd0; m_tc = 4'd0;
    @(posedge clk); #1 reset = 1'b0;

    // 17 taken branches wrap 4-bit counters back to 1
    for (int i = 0; i < 17; i++) begin
      step(32'h800, 32'h8, 0, 1, 0, 0, 1, 1, 32'h804, 1, 32'h808, 0);
      idle(1);
    end
    idle(1);
    @(negedge clk);
    chk("wrap_branch_cnt", 32'(br_if.branch_count), 32'd1);
    chk("wrap_taken_cnt",  32'(br_if.taken_count), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
